// File: rtl/jzjpcc_load_processor.sv
// Load-side memory/writeback stages: extracts, reorders and extends loaded data.
// Optional misaligned-load detection is enabled by defining JZJPCC_LOAD_MISALIGN_DETECT_EN.
module jzjpcc_load_processor (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        loadValid_execute,
  input  logic [2:0]  funct3_execute,
  input  logic [1:0]  byteOffset_execute,
  input  logic [4:0]  rdAddress_execute,
  input  logic [31:0] memData_memory,
  output logic        loadValid_writeback,
  output logic [31:0] loadData_writeback,
  output logic [4:0]  rdAddress_writeback,
  output logic        misaligned_writeback
);

  logic        r_m_valid;
  logic [2:0]  r_m_funct3;
  logic [1:0]  r_m_offset;
  logic [4:0]  r_m_rd;

  logic [31:0] r_hold_data;
  logic        r_held_valid;

  logic        r_w_valid;
  logic [31:0] r_w_data;
  logic [4:0]  r_w_rd;

  logic [31:0] w_raw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_word;
  logic [31:0] w_ext;
  logic        w_misaligned;

  // Memory data arrives in lane order; the stall-captured copy wins once taken.
  assign w_raw  = r_held_valid ? r_hold_data : memData_memory;
  assign w_word = {w_raw[7:0], w_raw[15:8], w_raw[23:16], w_raw[31:24]};

  always_comb begin
    w_byte = 8'h00;
    case (r_m_offset)
      2'd0: w_byte = w_raw[31:24];
      2'd1: w_byte = w_raw[23:16];
      2'd2: w_byte = w_raw[15:8];
      2'd3: w_byte = w_raw[7:0];
      default: w_byte = 8'h00;
    endcase
  end

  assign w_half = r_m_offset[1] ? {w_raw[7:0], w_raw[15:8]} : {w_raw[23:16], w_raw[31:24]};

  always_comb begin
    w_ext = 32'h0;
    case (r_m_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'h0, w_half};
      3'b010:  w_ext = w_word;
      default: w_ext = 32'h0;
    endcase
  end

`ifdef JZJPCC_LOAD_MISALIGN_DETECT_EN
  logic r_w_misaligned;

  assign w_misaligned = ((r_m_funct3[1:0] == 2'b01) && r_m_offset[0])
                      || ((r_m_funct3 == 3'b010) && (r_m_offset != 2'd0));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_w_misaligned <= 1'b0;
    end else if (!stall) begin
      r_w_misaligned <= r_m_valid && w_misaligned;
    end
  end

  assign misaligned_writeback = r_w_misaligned;
`else
  assign w_misaligned         = 1'b0;
  assign misaligned_writeback = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_m_valid    <= 1'b0;
      r_m_funct3   <= 3'b000;
      r_m_offset   <= 2'd0;
      r_m_rd       <= 5'd0;
      r_hold_data  <= 32'h0;
      r_held_valid <= 1'b0;
      r_w_valid    <= 1'b0;
      r_w_data     <= 32'h0;
      r_w_rd       <= 5'd0;
    end else if (stall) begin
      if (!r_held_valid) begin
        r_hold_data  <= memData_memory;
        r_held_valid <= 1'b1;
      end
      // A flush still kills the memory-stage load even while everything else holds.
      if (flush) begin
        r_m_valid <= 1'b0;
      end
    end else begin
      r_held_valid <= 1'b0;
      r_m_valid    <= loadValid_execute && !flush;
      r_m_funct3   <= funct3_execute;
      r_m_offset   <= byteOffset_execute;
      r_m_rd       <= rdAddress_execute;
      r_w_valid    <= r_m_valid && !w_misaligned;
      r_w_data     <= w_misaligned ? 32'h0 : w_ext;
      r_w_rd       <= r_m_rd;
    end
  end

  assign loadValid_writeback = r_w_valid;
  assign loadData_writeback  = r_w_data;
  assign rdAddress_writeback = r_w_rd;

endmodule

// File: tb/tb_jzjpcc_load_processor.sv
// Self-checking bench for jzjpcc_load_processor: pipelined vector table plus stall/flush sequences.
module tb_jzjpcc_load_processor;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        loadValid_execute;
  logic [2:0]  funct3_execute;
  logic [1:0]  byteOffset_execute;
  logic [4:0]  rdAddress_execute;
  logic [31:0] memData_memory;
  logic        loadValid_writeback;
  logic [31:0] loadData_writeback;
  logic [4:0]  rdAddress_writeback;
  logic        misaligned_writeback;

`ifdef JZJPCC_LOAD_MISALIGN_DETECT_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  jzjpcc_load_processor dut (
    .clock                (clock),
    .reset                (reset),
    .stall                (stall),
    .flush                (flush),
    .loadValid_execute    (loadValid_execute),
    .funct3_execute       (funct3_execute),
    .byteOffset_execute   (byteOffset_execute),
    .rdAddress_execute    (rdAddress_execute),
    .memData_memory       (memData_memory),
    .loadValid_writeback  (loadValid_writeback),
    .loadData_writeback   (loadData_writeback),
    .rdAddress_writeback  (rdAddress_writeback),
    .misaligned_writeback (misaligned_writeback)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [31:0] mem;
    logic        ev;
    logic [31:0] ed;
    logic        em;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  task automatic check_w(input string name, input logic ev, input logic [31:0] ed,
                         input logic [4:0] er, input logic em);
    tests_run++;
    if (loadValid_writeback !== ev || loadData_writeback !== ed ||
        rdAddress_writeback !== er || misaligned_writeback !== em) begin
      tests_failed++;
      $display("[TB] FAIL %s: got v=%b d=%h rd=%0d mis=%b expected v=%b d=%h rd=%0d mis=%b",
               name, loadValid_writeback, loadData_writeback, rdAddress_writeback,
               misaligned_writeback, ev, ed, er, em);
    end else begin
      $display("[TB] ok   %s: v=%b d=%h rd=%0d mis=%b", name, ev, ed, er, em);
    end
  endtask

  task automatic issue(input logic v, input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd);
    loadValid_execute  = v;
    funct3_execute     = f3;
    byteOffset_execute = off;
    rdAddress_execute  = rd;
  endtask

  initial begin
    vecs[0]  = '{3'b010, 2'd0, 5'd5,  32'h11223344, 1'b1, 32'h44332211, 1'b0};
    vecs[1]  = '{3'b000, 2'd1, 5'd6,  32'h00800000, 1'b1, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{3'b100, 2'd3, 5'd7,  32'h11223344, 1'b1, 32'h00000044, 1'b0};
    vecs[3]  = '{3'b001, 2'd0, 5'd8,  32'h34800000, 1'b1, 32'hFFFF8034, 1'b0};
    vecs[4]  = '{3'b101, 2'd2, 5'd9,  32'h00003480, 1'b1, 32'h00008034, 1'b0};
    vecs[5]  = '{3'b000, 2'd0, 5'd10, 32'h80000000, 1'b1, 32'hFFFFFF80, 1'b0};
    vecs[6]  = '{3'b100, 2'd2, 5'd11, 32'h0000AB00, 1'b1, 32'h000000AB, 1'b0};
    vecs[7]  = '{3'b001, 2'd2, 5'd12, 32'h00003480, 1'b1, 32'hFFFF8034, 1'b0};
    vecs[8]  = '{3'b011, 2'd0, 5'd13, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0};
    vecs[9]  = '{3'b111, 2'd0, 5'd14, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0};
    vecs[10] = '{3'b010, 2'd1, 5'd15, 32'h11223344, !MIS, MIS ? 32'h0 : 32'h44332211, MIS};
    vecs[11] = '{3'b001, 2'd1, 5'd16, 32'h34800000, !MIS, MIS ? 32'h0 : 32'hFFFF8034, MIS};
    vecs[12] = '{3'b101, 2'd3, 5'd17, 32'h00003480, !MIS, MIS ? 32'h0 : 32'h00008034, MIS};
    vecs[13] = '{3'b110, 2'd0, 5'd18, 32'h11223344, 1'b1, 32'h00000000, 1'b0};

    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    memData_memory = 32'h0;
    issue(1'b0, 3'b000, 2'd0, 5'd0);
    step();
    step();
    check("reset_valid", {31'h0, loadValid_writeback}, 32'h0);
    check("reset_data", loadData_writeback, 32'h0);
    check("reset_rd", {27'h0, rdAddress_writeback}, 32'h0);
    check("reset_mis", {31'h0, misaligned_writeback}, 32'h0);
    reset = 1'b0;

    // Back-to-back table: vector i is in execute during iteration i, its result shows after iteration i+1.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) issue(1'b1, vecs[i].f3, vecs[i].off, vecs[i].rd);
      else        issue(1'b0, 3'b000, 2'd0, 5'd0);
      memData_memory = (i >= 1) ? vecs[i-1].mem : 32'h0;
      step();
      if (i >= 1)
        check_w($sformatf("vec%0d", i-1), vecs[i-1].ev, vecs[i-1].ed, vecs[i-1].rd, vecs[i-1].em);
    end
    memData_memory = 32'h0;
    step();
    check("idle_valid", {31'h0, loadValid_writeback}, 32'h0);

    // Stall for three cycles starting in the memory-data cycle; data changes mid-stall.
    issue(1'b1, 3'b010, 2'd0, 5'd7);
    step();
    issue(1'b0, 3'b000, 2'd0, 5'd0);
    memData_memory = 32'h11223344;
    stall = 1'b1;
    step();
    check("stall_hold1", {31'h0, loadValid_writeback}, 32'h0);
    memData_memory = 32'hDEADBEEF;
    step();
    check("stall_hold2", {31'h0, loadValid_writeback}, 32'h0);
    step();
    check("stall_hold3", {31'h0, loadValid_writeback}, 32'h0);
    stall = 1'b0;
    step();
    check_w("stall_result", 1'b1, 32'h44332211, 5'd7, 1'b0);

    // Held data must be released once the stall ends.
    issue(1'b1, 3'b010, 2'd0, 5'd9);
    step();
    issue(1'b0, 3'b000, 2'd0, 5'd0);
    memData_memory = 32'hAABBCCDD;
    step();
    check_w("post_stall_fresh", 1'b1, 32'hDDCCBBAA, 5'd9, 1'b0);

    // LB, LB back-to-back; flush on the edge that moves the second into the memory stage.
    issue(1'b1, 3'b000, 2'd0, 5'd1);
    step();
    issue(1'b1, 3'b000, 2'd0, 5'd2);
    memData_memory = 32'h80000000;
    flush = 1'b1;
    step();
    check_w("flush_first", 1'b1, 32'hFFFFFF80, 5'd1, 1'b0);
    flush = 1'b0;
    issue(1'b0, 3'b000, 2'd0, 5'd0);
    memData_memory = 32'h7F000000;
    step();
    check("flush_second_killed", {31'h0, loadValid_writeback}, 32'h0);

    // Stall and flush together: load in memory stage is killed, writeback held.
    issue(1'b1, 3'b100, 2'd0, 5'd3);
    step();
    issue(1'b0, 3'b000, 2'd0, 5'd0);
    memData_memory = 32'h5A000000;
    stall = 1'b1;
    flush = 1'b1;
    step();
    check("stallflush_hold", {31'h0, loadValid_writeback}, 32'h0);
    stall = 1'b0;
    flush = 1'b0;
    step();
    check("stallflush_killed", {31'h0, loadValid_writeback}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
